// File: rtl/opsum_writeback_pkg.sv
// Shared encodings for the GLB-side controllers: the input feed controller and
// the opsum writeback responder.
package opsum_writeback_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_LOAD,
    FEED_SEND,
    FEED_DONE
  } feed_state_t;

  typedef enum logic [1:0] {
    OPSUM_WB_IDLE,
    OPSUM_WB_RECV,
    OPSUM_WB_FLUSH,
    OPSUM_WB_DONE
  } opsum_wb_state_t;

  localparam int unsigned GLB_WORD_BYTES = 4;
  localparam logic [3:0]  GLB_WE_ALL     = 4'b1111;
  localparam logic [3:0]  GLB_WE_NONE    = 4'b0000;

  // Byte address of word idx above base; wraps at 32 bits.
  function automatic logic [31:0] glb_word_addr(input logic [31:0] base,
                                                input logic [31:0] idx);
    return base + idx * GLB_WORD_BYTES;
  endfunction

endpackage

// File: rtl/opsum_writeback.sv
// GON responder: collects opsums from the PE array, optionally applies ReLU,
// and writes them to consecutive GLB words starting at a programmed base.
module opsum_writeback
  import opsum_writeback_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 relu_en,
  input  logic [31:0]          opsum_baseaddr,
  input  logic [CNT_BITS-1:0]  num_words,
  output logic                 done,
  output logic                 busy,
  input  logic                 GLB_opsum_valid,
  output logic                 GLB_opsum_ready,
  input  logic [DATA_SIZE-1:0] PE_data_out,
  output logic [3:0]           glb_we,
  output logic [31:0]          glb_w_addr,
  output logic [DATA_SIZE-1:0] glb_w_data
);

  opsum_wb_state_t      state_reg;
  logic [CNT_BITS-1:0]  recv_cnt_reg;
  logic [CNT_BITS-1:0]  num_words_reg;
  logic [31:0]          base_reg;
  logic                 relu_reg;
  logic                 ready_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [3:0]           we_reg;
  logic [31:0]          addr_reg;
  logic [DATA_SIZE-1:0] data_reg;

  logic                 handshake;
  logic                 last_word;
  logic [DATA_SIZE-1:0] relu_data;

  assign handshake = GLB_opsum_valid && ready_reg;
  assign last_word = (recv_cnt_reg + CNT_BITS'(1)) == num_words_reg;
  assign relu_data = (relu_reg && PE_data_out[DATA_SIZE-1]) ? '0 : PE_data_out;

  // Ready is a flop that mirrors the RECV state, so it never depends on valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= OPSUM_WB_IDLE;
      recv_cnt_reg  <= '0;
      num_words_reg <= '0;
      base_reg      <= '0;
      relu_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      we_reg        <= GLB_WE_NONE;
      addr_reg      <= '0;
      data_reg      <= '0;
    end else begin
      we_reg   <= GLB_WE_NONE;
      done_reg <= 1'b0;

      if (handshake) begin
        we_reg       <= GLB_WE_ALL;
        addr_reg     <= glb_word_addr(base_reg, 32'(recv_cnt_reg));
        data_reg     <= relu_data;
        recv_cnt_reg <= recv_cnt_reg + CNT_BITS'(1);
      end

      case (state_reg)
        OPSUM_WB_IDLE: begin
          if (start) begin
            base_reg      <= opsum_baseaddr;
            num_words_reg <= num_words;
            relu_reg      <= relu_en;
            recv_cnt_reg  <= '0;
            if (num_words == '0) begin
              state_reg <= OPSUM_WB_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= OPSUM_WB_RECV;
              ready_reg <= 1'b1;
              busy_reg  <= 1'b1;
            end
          end
        end
        OPSUM_WB_RECV: begin
          if (handshake && last_word) begin
            state_reg <= OPSUM_WB_FLUSH;
            ready_reg <= 1'b0;
          end
        end
        OPSUM_WB_FLUSH: begin
          state_reg <= OPSUM_WB_DONE;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
        end
        OPSUM_WB_DONE: begin
          state_reg <= OPSUM_WB_IDLE;
        end
        default: begin
          state_reg <= OPSUM_WB_IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign done            = done_reg;
  assign busy            = busy_reg;
  assign GLB_opsum_ready = ready_reg;
  assign glb_we          = we_reg;
  assign glb_w_addr      = addr_reg;
  assign glb_w_data      = data_reg;

endmodule

// File: doc/opsum_writeback.md
# opsum_writeback

Output-side counterpart of the GLB-to-PE feed controller. It is the GON responder: it accepts output partial sums from the PE array over the GLB_opsum valid/ready handshake, optionally applies ReLU, and writes each word into the global buffer at consecutive word addresses from a programmed base. It sits between the PE array GON port and the GLB write port and signals completion to the layer-level controller.

## Interface
- DATA_SIZE, default 32 — opsum / GLB word width in bits (must be 32 for 4 byte lanes)
- CNT_BITS, default 16 — width of the opsum word counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; launches a writeback pass (ignored unless IDLE)
- relu_en  in  1  when 1, negative opsums are written as 0; sampled at start
- opsum_baseaddr  in  32  GLB byte address of first opsum; sampled at start
- num_words  in  CNT_BITS  opsums to collect this pass; sampled at start
- done  out  1  one-cycle pulse when the pass is complete
- busy  out  1  high from the cycle after start until done
- GLB_opsum_valid  in  1  PE array has an opsum on PE_data_out
- GLB_opsum_ready  out  1  block accepts an opsum this cycle
- PE_data_out  in  DATA_SIZE  opsum data, two's complement
- glb_we  out  4  GLB byte write enables
- glb_w_addr  out  32  GLB write byte address
- glb_w_data  out  DATA_SIZE  GLB write data

## Operation
- States: IDLE, RECV, FLUSH, DONE.
- IDLE: GLB_opsum_ready=0, glb_we=0. On start: latch base, num_words, relu_en; clear recv_cnt; go RECV, or go DONE if num_words==0.
- RECV: GLB_opsum_ready=1. Handshake fires when valid&&ready. On each handshake: capture data into write register (ReLU applied if latched relu_en and bit DATA_SIZE-1 set → 0), set write address = base + 4*recv_cnt (32-bit wrap, no saturation), increment recv_cnt. When the handshake taking recv_cnt to num_words fires, go FLUSH; ready is low from the next cycle on.
- FLUSH: last write is on the port this cycle; go DONE.
- DONE: done=1 for one cycle; go IDLE.
- Write stage: one registered stage; glb_we=4'b1111 exactly one cycle after each handshake, else 4'b0000. glb_w_addr/glb_w_data hold their last value when glb_we=0.
- GLB write always completes in one cycle; no back-pressure from GLB, so no buffering beyond the write register is needed.
- valid without ready (IDLE, FLUSH, DONE): data not consumed; PE array must hold it.
- start while busy: ignored, latched parameters unchanged.
- Extra opsums beyond num_words are never accepted.

## Timing
- Reset values: state IDLE, done 0, busy 0, GLB_opsum_ready 0, glb_we 0, glb_w_addr 0, glb_w_data 0, recv_cnt 0.
- Reset mid-pass: everything returns to reset values immediately; a partially issued pass is abandoned, with no done.
- Throughput: one opsum per cycle with continuous valid.
- Latency: handshake in cycle n → glb_we in cycle n+1 → (if last) done in cycle n+2.
- GLB_opsum_ready is a registered, state-derived output; it does not depend combinationally on GLB_opsum_valid.
- busy = (state != IDLE) && (state != DONE) is low in the done cycle.

## Structure
- Shared package (already holding the controller state encodings): add OPSUM_WB_IDLE/RECV/FLUSH/DONE enum and constant GLB_WORD_BYTES=4.
- Single module with no sub-modules; the ReLU is a one-line mux and does not justify its own block.

## Test plan
- Basic: base=0x100, num_words=4, valid held high, data 1,2,3,4 → writes (0x100,1),(0x104,2),(0x108,3),(0x10C,4) on consecutive cycles; done pulses 2 cycles after the 4th handshake.
- ReLU: relu_en=1, data 0xFFFF_FFF6, 5 → writes 0, 5; with relu_en=0 → 0xFFFF_FFF6, 5.
- Bubbles: valid toggles 1,0,0,1,1 with num_words=3 → exactly 3 writes at base+0/4/8, none during bubbles, recv_cnt never exceeds 3; a 4th valid stays unaccepted (ready=0).
- Zero length: start with num_words=0 → done one cycle later, no glb_we, ready never asserted.
- Async reset: assert rst after 2 of 5 handshakes → outputs at reset values within the same cycle, no done; a new start with base=0x200 then writes from 0x200.
- Start while busy: second start mid-pass with base=0x300 → ignored, addresses continue from the original base.
